// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM encoding, word constants and
// the branch-offset helper used by fetch and execute.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Branch immediate: sign-extend bit 15 into [31:18], word offset shifted left by 2.
  function automatic logic [XLEN-1:0] sext_shl2(input logic [IMM_W-1:0] imm);
    return {{(XLEN - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational sequential-PC and PC-relative branch target adders.
// Shared by the fetch stage and the execute-stage branch logic.
module branch_target_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic [IMM_W-1:0] imm16,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  branch_target
);

  // Both sums wrap modulo 2^32; carries are intentionally dropped.
  assign pc_plus4      = pc + XLEN'(WORD_BYTES);
  assign branch_target = pc_plus4 + sext_shl2(imm16);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, imem req/ready handshake and the
// decode-facing instruction register. Optional FETCH_PERF_CNT_EN adds counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] branch_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_stall_cnt
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(WORD_BYTES - 1);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            fetch_done;

  // Never request while a held instruction is blocked or a redirect is pending.
  assign imem_req   = (state == RUN) && !(instr_valid && stall) && !redirect_valid;
  assign imem_addr  = pc;
  assign fetch_done = imem_req && imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
    end else if (redirect_valid) begin
      // Redirect beats stall and discards any data returning this cycle.
      state       <= FLUSH;
      pc          <= redirect_pc & ALIGN_MASK;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     state <= RUN;
        FLUSH:   state <= RUN;
        default: state <= IDLE;
      endcase
      if (fetch_done) begin
        instr_out   <= imem_rdata;
        pc_out      <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + XLEN'(WORD_BYTES);
      end else if (!stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

  branch_target_calc u_btc (
    .pc            (pc_out),
    .imm16         (instr_out[IMM_W-1:0]),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_done && (perf_fetch_cnt != '1)) begin
        perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
      end
      if (instr_valid && stall && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
      end
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + constrained-random bench for fetch_stage with a reference model.
// Build with FETCH_PERF_CNT_EN defined to also check the performance counters.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .branch_target  (branch_target)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Instruction memory contents: two fixed branch words, otherwise address-derived.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h1000_FFFE;
      32'h0000_0044: return 32'h1000_0003;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_wait counts the request-free cycles still owed after reset or a redirect.
  bit          m_init = 0;
  int          m_wait;
  logic [31:0] m_pc, m_instr, m_pcout;
  logic        m_valid;
  longint      m_fetches, m_stalls;

  function automatic logic model_req();
    return (m_wait == 0) && !(m_valid && stall) && !redirect_valid;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_wait = 1; m_pc = 32'h0; m_valid = 0;
      m_instr = 32'h0; m_pcout = 32'h0; m_fetches = 0; m_stalls = 0;
    end else begin
      logic req;
      req = model_req();
      if (m_valid && stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (redirect_valid) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_valid = 0;
        m_wait = 1;
      end else begin
        if (m_wait > 0) m_wait--;
        if (req && imem_ready) begin
          m_instr = rom(m_pc);
          m_pcout = m_pc;
          m_valid = 1;
          m_pc = m_pc + 32'd4;
          if (m_fetches < 64'hFFFF_FFFF) m_fetches++;
        end else if (!stall) begin
          m_valid = 0;
        end
      end
    end
  end

  // Compare every cycle, mid-period, once the model has seen a reset.
  always @(negedge clk) begin
    if (m_init) begin
      logic [31:0] offs;
      offs = {{16{m_instr[15]}}, m_instr[15:0]} * 32'd4;
      chk("imem_req",      {31'b0, imem_req},    {31'b0, model_req()});
      chk("imem_addr",     imem_addr,            m_pc);
      chk("instr_valid",   {31'b0, instr_valid}, {31'b0, m_valid});
      chk("instr_out",     instr_out,            m_instr);
      chk("pc_out",        pc_out,               m_pcout);
      chk("pc_plus4",      pc_plus4,             m_pcout + 32'd4);
      chk("branch_target", branch_target,        m_pcout + 32'd4 + offs);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetches));
      chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stalls));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid",  {31'b0, instr_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr",  instr_out, 32'h0);
    chk("rst_req",    {31'b0, imem_req}, 32'd0);
    rst = 0;

    tick();                                   // IDLE -> RUN
    chk("idle_valid", {31'b0, instr_valid}, 32'd0);
    chk("run_req",    {31'b0, imem_req}, 32'd1);
    chk("run_addr0",  imem_addr, 32'h0);
    tick();
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pc",    pc_out, 32'h0);
    chk("addr_lead",   imem_addr, 32'h4);
    tick(); chk("seq_pc4", pc_out, 32'h4);
    tick(); chk("seq_pc8", pc_out, 32'h8);

    stall = 1; #1;
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",    pc_out, 32'h8);
      chk("stall_instr", instr_out, rom(32'h8));
    end
    stall = 0; #1;
    chk("release_addr", imem_addr, 32'hC);
    tick(); chk("seq_pc12", pc_out, 32'hC);

    imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("nordy_valid", {31'b0, instr_valid}, 32'd0);
      chk("nordy_addr",  imem_addr, 32'h10);
    end
    imem_ready = 1;
    tick(); chk("nordy_resume", pc_out, 32'h10);

    redirect_valid = 1; redirect_pc = 32'h100; #1;
    chk("redir_req", {31'b0, imem_req}, 32'd0);
    tick();
    redirect_valid = 0; #1;
    chk("flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("flush_req",   {31'b0, imem_req}, 32'd0);
    tick();
    chk("post_flush_addr", imem_addr, 32'h100);
    tick(); chk("redir_pc_out", pc_out, 32'h100);

    stall = 1; redirect_valid = 1; redirect_pc = 32'h42;
    tick();
    stall = 0; redirect_valid = 0; #1;
    chk("redir_stall_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_align",       imem_addr, 32'h40);
    tick(); tick();
    chk("br_pc",     pc_out, 32'h40);
    chk("br_plus4",  pc_plus4, 32'h44);
    chk("br_back",   branch_target, 32'h3C);
    tick();
    chk("br_fwd",    branch_target, 32'h54);
    tick(); tick();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch10", perf_fetch_cnt, 32'd10);
    chk("perf_stall4",  perf_stall_cnt, 32'd4);
`endif

    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    tick(); tick();
    chk("wrap_pc",    pc_out, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    tick();
    chk("wrap_next",  pc_out, 32'h0);

    rst = 1;
    tick();
    rst = 0; #1;
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_addr",  imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_fcnt", perf_fetch_cnt, 32'd0);
    chk("midrst_scnt", perf_stall_cnt, 32'd0);
`endif
    tick(); tick();
    chk("midrst_first", pc_out, 32'h0);

    // Mixed traffic checked entirely by the model.
    for (int i = 0; i < 400; i++) begin
      tick();
      stall          = ($urandom_range(0, 3) == 0);
      imem_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
    end
    tick();
    stall = 0; redirect_valid = 0; imem_ready = 1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
